uart_mcb_cmd_bridge: RTL and testbench

Protocol engine between the UART byte layer and MCB user port 0 in the UART-to-DDR3 test design.
- Parses framed commands from received UART bytes.
- Issues single-beat 128-bit write or read transactions on port 0.
- Returns an ack byte or read data bytes through a byte-wide transmit handshake.
- Output ports connect directly to the UART transmitter and the MCB p0 cmd, wr and rd FIFOs.

---
 rtl/uart_mcb_cmd_bridge.sv | 157 +++++++++++++++
 tb/tb_uart_mcb_cmd_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mcb_cmd_bridge.sv
// UART command bridge to MCB port 0: parses W/R frames, issues single-beat
// 128-bit write/read transactions and returns an ack byte or the 16 read bytes.
module uart_mcb_cmd_bridge #(
  parameter int C3_P0_DATA_PORT_SIZE = 128,
  parameter int C3_P0_MASK_SIZE      = 16,
  parameter int ADDR_BYTES           = 4,
  parameter int TIMEOUT_CYC          = 1000000
) (
  input  logic                            sys_clk_i,
  input  logic                            sys_rst_i,
  input  logic                            calib_done_i,
  input  logic [7:0]                      rx_data_i,
  input  logic                            rx_valid_i,
  output logic [7:0]                      tx_data_o,
  output logic                            tx_valid_o,
  input  logic                            tx_ready_i,
  output logic                            p0_cmd_en_o,
  output logic [2:0]                      p0_cmd_instr_o,
  output logic [5:0]                      p0_cmd_bl_o,
  output logic [29:0]                     p0_cmd_byte_addr_o,
  input  logic                            p0_cmd_full_i,
  output logic                            p0_wr_en_o,
  output logic [C3_P0_MASK_SIZE-1:0]      p0_wr_mask_o,
  output logic [C3_P0_DATA_PORT_SIZE-1:0] p0_wr_data_o,
  input  logic                            p0_wr_full_i,
  output logic                            p0_rd_en_o,
  input  logic [C3_P0_DATA_PORT_SIZE-1:0] p0_rd_data_i,
  input  logic                            p0_rd_empty_i,
  output logic                            busy_o,
  output logic                            err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, WDATA, WR_PUSH, WR_CMD, RD_CMD, RD_WAIT, TX_DATA, TX_ACK
  } state_t;

  state_t                          state, state_d;
  logic [4:0]                      cnt;
  logic [TW-1:0]                   tmo;
  logic                            is_wr;
  logic [29:0]                     addr;
  logic [C3_P0_DATA_PORT_SIZE-1:0] data;
  logic [7:0]                      ack;
  logic                            err_set;
  logic                            byte_in;
  logic                            tx_fire;
  logic                            tmo_hit;
  logic                            tmo_run;

  // TX handshake: a byte moves only in a cycle where tx_valid_o and tx_ready_i
  // are both high; until then tx_data_o/tx_valid_o hold, since they are
  // decoded from registered state and data only.
  assign tx_fire = tx_valid_o && tx_ready_i;
  assign byte_in = rx_valid_i && (state == ADDR || state == WDATA);
  assign tmo_run = (state == ADDR) || (state == WDATA) || (state == RD_WAIT);
  assign tmo_hit = (tmo == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid_i) begin
          if ((rx_data_i == 8'h57 || rx_data_i == 8'h52) && calib_done_i) begin
            state_d = ADDR;
          end else begin
            state_d = TX_ACK;
            err_set = 1'b1;
          end
        end
      end
      ADDR: begin
        if (rx_valid_i && cnt == 5'(ADDR_BYTES - 1)) state_d = is_wr ? WDATA : RD_CMD;
        else if (tmo_hit) begin
          state_d = TX_ACK;
          err_set = 1'b1;
        end
      end
      WDATA: begin
        if (rx_valid_i && cnt == 5'd15) state_d = WR_PUSH;
        else if (tmo_hit) begin
          state_d = TX_ACK;
          err_set = 1'b1;
        end
      end
      WR_PUSH: if (!p0_wr_full_i) state_d = WR_CMD;
      WR_CMD:  if (!p0_cmd_full_i) state_d = TX_ACK;
      RD_CMD:  if (!p0_cmd_full_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (!p0_rd_empty_i) state_d = TX_DATA;
        else if (tmo_hit) begin
          state_d = TX_ACK;
          err_set = 1'b1;
        end
      end
      TX_DATA: if (tx_fire && cnt == 5'd15) state_d = IDLE;
      TX_ACK:  if (tx_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      tmo   <= '0;
      is_wr <= 1'b0;
      addr  <= '0;
      data  <= '0;
      ack   <= 8'h00;
      err_o <= 1'b0;
    end else begin
      state <= state_d;
      if (err_set) err_o <= 1'b1;

      if (state_d != state) cnt <= '0;
      else if (byte_in || (state == TX_DATA && tx_fire)) cnt <= cnt + 5'd1;

      if (state_d != state || byte_in || !tmo_run) tmo <= '0;
      else tmo <= tmo + TW'(1);

      if (state == IDLE && rx_valid_i) is_wr <= (rx_data_i == 8'h57);

      // Low nibble is zeroed as the final address byte lands, so it never shifts up.
      if (state == ADDR && rx_valid_i) begin
        if (cnt == 5'(ADDR_BYTES - 1)) addr <= {addr[21:0], rx_data_i[7:4], 4'h0};
        else addr <= {addr[21:0], rx_data_i};
      end

      if (state == WDATA && rx_valid_i) data <= {rx_data_i, data[C3_P0_DATA_PORT_SIZE-1:8]};
      else if (state == RD_WAIT && !p0_rd_empty_i) data <= p0_rd_data_i;
      else if (state == TX_DATA && tx_fire) data <= data >> 8;

      if (state_d == TX_ACK && state != TX_ACK) ack <= (state == WR_CMD) ? 8'h4B : 8'h45;
    end
  end

  always_comb begin
    tx_data_o = 8'h00;
    if (state == TX_DATA) tx_data_o = data[7:0];
    else if (state == TX_ACK) tx_data_o = ack;
  end

  assign tx_valid_o         = (state == TX_DATA) || (state == TX_ACK);
  assign busy_o             = (state != IDLE);
  assign p0_cmd_en_o        = (state == WR_CMD || state == RD_CMD) && !p0_cmd_full_i;
  assign p0_cmd_instr_o     = (state == RD_CMD) ? 3'b001 : 3'b000;
  assign p0_cmd_bl_o        = 6'd0;
  assign p0_cmd_byte_addr_o = addr;
  assign p0_wr_en_o         = (state == WR_PUSH) && !p0_wr_full_i;
  assign p0_wr_mask_o       = '0;
  assign p0_wr_data_o       = data;
  assign p0_rd_en_o         = (state == RD_WAIT) && !p0_rd_empty_i;

endmodule

// File: tb/tb_uart_mcb_cmd_bridge.sv
// Directed bench for uart_mcb_cmd_bridge: expected MCB strobes and TX bytes are
// queued by the stimulus and checked by an independent monitor.
module tb_uart_mcb_cmd_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         calib = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic         cmd_en;
  logic [2:0]   cmd_instr;
  logic [5:0]   cmd_bl;
  logic [29:0]  cmd_addr;
  logic         cmd_full = 1'b0;
  logic         wr_en;
  logic [15:0]  wr_mask;
  logic [127:0] wr_data;
  logic         wr_full = 1'b0;
  logic         rd_en;
  logic [127:0] rd_data = '0;
  logic         rd_empty = 1'b1;
  logic         busy;
  logic         err;

  uart_mcb_cmd_bridge #(.TIMEOUT_CYC(100)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .calib_done_i(calib),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .p0_cmd_en_o(cmd_en), .p0_cmd_instr_o(cmd_instr), .p0_cmd_bl_o(cmd_bl),
    .p0_cmd_byte_addr_o(cmd_addr), .p0_cmd_full_i(cmd_full),
    .p0_wr_en_o(wr_en), .p0_wr_mask_o(wr_mask), .p0_wr_data_o(wr_data),
    .p0_wr_full_i(wr_full),
    .p0_rd_en_o(rd_en), .p0_rd_data_i(rd_data), .p0_rd_empty_i(rd_empty),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]   exp_tx_q[$];
  logic [32:0]  exp_cmd_q[$];
  logic [127:0] exp_wr_q[$];
  int act_wr_cnt = 0;
  int act_cmd_cnt = 0;
  int act_rd_cnt = 0;
  int exp_rd_cnt = 0;
  logic wr_pending = 1'b0;
  int rd_countdown = 0;
  logic rd_pop = 1'b0;
  logic [127:0] rd_pat = '0;
  logic tx_mode = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected_strobe required=none", name);
  endtask

  // Environment model: transmitter ready pattern and read FIFO data return.
  initial begin
    int cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      tx_ready = tx_mode ? (cyc % 4 == 0) : 1'b1;
      if (rd_pop) begin
        rd_empty = 1'b1;
        rd_pop = 1'b0;
      end
      if (rd_countdown > 0) begin
        rd_countdown--;
        if (rd_countdown == 0) begin
          rd_data = rd_pat;
          rd_empty = 1'b0;
        end
      end
    end
  end

  // Monitor: samples mid-cycle and pops the scoreboard queues.
  initial begin
    logic prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_hold = 1'b0;
        wr_pending = 1'b0;
      end else begin
        if (wr_en) begin
          act_wr_cnt++;
          chk("wr_not_full", 128'(wr_full), 128'(0));
          chk("wr_mask", 128'(wr_mask), 128'(0));
          if (exp_wr_q.size() == 0) unexpected("wr_en");
          else chk("wr_data", wr_data, exp_wr_q.pop_front());
          wr_pending = 1'b1;
        end
        if (cmd_en) begin
          act_cmd_cnt++;
          chk("cmd_not_full", 128'(cmd_full), 128'(0));
          chk("cmd_bl", 128'(cmd_bl), 128'(0));
          if (cmd_instr == 3'b000) begin
            chk("wr_before_cmd", 128'(wr_pending), 128'(1));
            wr_pending = 1'b0;
          end
          if (cmd_instr == 3'b001) rd_countdown = 3;
          if (exp_cmd_q.size() == 0) unexpected("cmd_en");
          else chk("cmd_instr_addr", 128'({cmd_instr, cmd_addr}), 128'(exp_cmd_q.pop_front()));
        end
        if (rd_en) begin
          act_rd_cnt++;
          chk("rd_not_empty", 128'(rd_empty), 128'(0));
          rd_pop = 1'b1;
        end
        if (prev_hold) begin
          chk("tx_valid_hold", 128'(tx_valid), 128'(1));
          chk("tx_data_hold", 128'(tx_data), 128'(prev_data));
        end
        if (tx_valid && tx_ready) begin
          if (exp_tx_q.size() == 0) unexpected("tx_byte");
          else chk("tx_byte", 128'(tx_data), 128'(exp_tx_q.pop_front()));
        end
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [31:0] a);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
  endtask

  task automatic send_data(input logic [127:0] d);
    for (int i = 0; i < 16; i++) send_byte(d[i*8 +: 8]);
  endtask

  task automatic push_tx_data(input logic [127:0] d);
    for (int i = 0; i < 16; i++) exp_tx_q.push_back(d[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((busy || exp_tx_q.size() != 0 || exp_cmd_q.size() != 0 || exp_wr_q.size() != 0)
           && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s actual=still_busy required=idle_within_%0d", name, budget);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    #2;
    chk({tag, "_tx_valid"}, 128'(tx_valid), 128'(0));
    chk({tag, "_tx_data"}, 128'(tx_data), 128'(0));
    chk({tag, "_cmd_en"}, 128'(cmd_en), 128'(0));
    chk({tag, "_wr_en"}, 128'(wr_en), 128'(0));
    chk({tag, "_rd_en"}, 128'(rd_en), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [127:0] PAT_A = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] PAT_B = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [127:0] PAT_C = 128'h112233445566778899AABBCCDDEEFF00;

  initial begin
    int wr_before;
    int cmd_before;
    reset_check("reset");

    // Basic write.
    exp_wr_q.push_back(PAT_A);
    exp_cmd_q.push_back({3'b000, 30'h120});
    exp_tx_q.push_back(8'h4B);
    send_hdr(8'h57, 32'h0000_0120);
    send_data(PAT_A);
    wait_idle("write_basic", 200);

    // Basic read.
    rd_pat = PAT_A;
    exp_rd_cnt++;
    exp_cmd_q.push_back({3'b001, 30'h120});
    push_tx_data(PAT_A);
    send_hdr(8'h52, 32'h0000_0120);
    wait_idle("read_basic", 200);

    // Write with wr FIFO full for 20 cycles, then cmd FIFO full for 10 more.
    wr_full = 1'b1;
    cmd_full = 1'b1;
    exp_wr_q.push_back(PAT_C);
    exp_cmd_q.push_back({3'b000, 30'h2000_0040});
    exp_tx_q.push_back(8'h4B);
    send_hdr(8'h57, 32'hE000_0040);
    send_data(PAT_C);
    wr_before = act_wr_cnt;
    cmd_before = act_cmd_cnt;
    repeat (20) @(negedge clk);
    chk("no_wr_while_full", 128'(act_wr_cnt), 128'(wr_before));
    wr_full = 1'b0;
    repeat (10) @(negedge clk);
    chk("one_wr_after_release", 128'(act_wr_cnt), 128'(wr_before + 1));
    chk("no_cmd_while_full", 128'(act_cmd_cnt), 128'(cmd_before));
    cmd_full = 1'b0;
    wait_idle("write_backpressure", 200);
    chk("one_cmd_after_release", 128'(act_cmd_cnt), 128'(cmd_before + 1));

    // Read with a slow transmitter; low address nibble forced to zero.
    rd_pat = PAT_B;
    exp_rd_cnt++;
    exp_cmd_q.push_back({3'b001, 30'h0000_3450});
    push_tx_data(PAT_B);
    tx_mode = 1'b1;
    send_hdr(8'h52, 32'h0000_345F);
    wait_idle("read_slow_tx", 400);
    tx_mode = 1'b0;
    chk("err_clear_after_good_frames", 128'(err), 128'(0));

    // Bad opcode.
    exp_tx_q.push_back(8'h45);
    send_byte(8'h41);
    wait_idle("bad_opcode", 50);
    chk("err_bad_opcode", 128'(err), 128'(1));

    // Not calibrated.
    calib = 1'b0;
    exp_tx_q.push_back(8'h45);
    send_byte(8'h57);
    wait_idle("no_calib", 50);
    calib = 1'b1;

    // Frame stalled after 3 address bytes.
    reset_check("reset2");
    exp_tx_q.push_back(8'h45);
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    repeat (50) @(negedge clk);
    #2;
    chk("stall_still_busy", 128'(busy), 128'(1));
    chk("stall_no_early_err", 128'(err), 128'(0));
    wait_idle("timeout", 300);
    chk("timeout_err", 128'(err), 128'(1));
    chk("timeout_idle", 128'(busy), 128'(0));

    // Reset mid-WDATA, then a clean write to address 0.
    send_hdr(8'h57, 32'h0000_0000);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    reset_check("reset_mid");
    exp_wr_q.push_back(PAT_B);
    exp_cmd_q.push_back({3'b000, 30'h0});
    exp_tx_q.push_back(8'h4B);
    send_hdr(8'h57, 32'h0000_0000);
    send_data(PAT_B);
    wait_idle("write_after_reset", 200);

    chk("tx_q_drained", 128'(exp_tx_q.size()), 128'(0));
    chk("cmd_q_drained", 128'(exp_cmd_q.size()), 128'(0));
    chk("wr_q_drained", 128'(exp_wr_q.size()), 128'(0));
    chk("rd_pop_count", 128'(act_rd_cnt), 128'(exp_rd_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
